// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: shared field layout, reset constants, ack FSM states and
// month-length helper. Build option: TIME_KEEPER_LEAP_EN enables Feb 29 on
// years divisible by four.
package time_keeper_pkg;

    localparam int unsigned TIME_W        = 17;
    localparam int unsigned DATE_W        = 16;
    localparam int unsigned MODE_W        = 6;
    localparam int unsigned MODE_STOP_BIT = 0;

    localparam int unsigned HOUR_HI  = 16;
    localparam int unsigned HOUR_LO  = 12;
    localparam int unsigned MIN_HI   = 11;
    localparam int unsigned MIN_LO   = 6;
    localparam int unsigned SEC_HI   = 5;
    localparam int unsigned SEC_LO   = 0;
    localparam int unsigned YEAR_HI  = 15;
    localparam int unsigned YEAR_LO  = 9;
    localparam int unsigned MONTH_HI = 8;
    localparam int unsigned MONTH_LO = 5;
    localparam int unsigned DAY_HI   = 4;
    localparam int unsigned DAY_LO   = 0;

    localparam logic [DATE_W-1:0] RESET_DATE = 16'h0021;

    typedef struct packed {
        logic [HOUR_HI-HOUR_LO:0] hour;
        logic [MIN_HI-MIN_LO:0]   min;
        logic [SEC_HI-SEC_LO:0]   sec;
    } tk_time_t;

    typedef struct packed {
        logic [YEAR_HI-YEAR_LO:0]   year;
        logic [MONTH_HI-MONTH_LO:0] month;
        logic [DAY_HI-DAY_LO:0]     day;
    } tk_date_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } ack_state_t;

    // Days in the given month; year only matters for February.
    function automatic logic [4:0] month_len(input logic [3:0] month,
                                             input logic [6:0] year);
        logic [4:0] len;
        logic       unused_year;
        unused_year = ^year;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
`ifdef TIME_KEEPER_LEAP_EN
            4'd2:                    len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
            4'd2:                    len = 5'd28;
`endif
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// time_keeper_if: setting handshake between the key controller and the
// time keeper.
interface time_keeper_if;
    import time_keeper_pkg::*;

    logic              SETTING;
    logic              ALARM_SETTING;
    logic [TIME_W-1:0] SET_TIME;
    logic [DATE_W-1:0] SET_DATE;
    logic [TIME_W-1:0] SET_ALARM;
    logic              SETTING_OK;

    modport master (
        output SETTING, ALARM_SETTING, SET_TIME, SET_DATE, SET_ALARM,
        input  SETTING_OK
    );

    modport slave (
        input  SETTING, ALARM_SETTING, SET_TIME, SET_DATE, SET_ALARM,
        output SETTING_OK
    );

endinterface

// File: rtl/tk_prescaler.sv
// tk_prescaler: divides CLK down to a one-second tick, with hold and clear.
module tk_prescaler #(
    parameter int unsigned CLK_HZ = 1000000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic hold,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = !hold && (cnt == CNT_MAX);

    // Free-running divider; clear beats hold, hold freezes the count.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            if (cnt == CNT_MAX) cnt <= '0;
            else                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: real-time clock/calendar with setting handshake and alarm.
// Build option: TIME_KEEPER_LEAP_EN (see time_keeper_pkg::month_len).
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 1000000,
    parameter int unsigned ALARM_SEC = 30
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [MODE_W-1:0] MODE,
    input  logic              ALARM_ENABLE,
    time_keeper_if.slave      SET_BUS,
    output logic [TIME_W-1:0] CUR_TIME,
    output logic [DATE_W-1:0] CUR_DATE,
    output logic [TIME_W-1:0] CUR_ALARM,
    output logic              SEC_TICK,
    output logic              ALARM_HIT
);

    localparam int unsigned REM_W = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;

    ack_state_t       state;
    logic             setting_ok;
    tk_time_t         cur_t;
    tk_date_t         cur_d;
    tk_time_t         alarm_t;
    tk_time_t         nxt_t;
    tk_date_t         nxt_d;
    tk_time_t         ld_t;
    tk_date_t         ld_d;
    tk_time_t         ld_a;
    logic             sec_tick;
    logic             alarm_hit;
    logic [REM_W-1:0] alarm_rem;

    logic tick_c;
    logic req_c;
    logic load_time_c;
    logic load_alarm_c;
    logic tick_take_c;
    logic unused_mode;

    assign unused_mode  = ^MODE[MODE_W-1:MODE_STOP_BIT+1];
    assign req_c        = SET_BUS.SETTING | SET_BUS.ALARM_SETTING;
    assign load_time_c  = (state == ST_IDLE) && SET_BUS.SETTING;
    assign load_alarm_c = (state == ST_IDLE) && SET_BUS.ALARM_SETTING;
    assign tick_take_c  = tick_c && !(load_time_c || load_alarm_c);

    assign SET_BUS.SETTING_OK = setting_ok;
    assign CUR_TIME  = cur_t;
    assign CUR_DATE  = cur_d;
    assign CUR_ALARM = alarm_t;
    assign SEC_TICK  = sec_tick;
    assign ALARM_HIT = alarm_hit;

    tk_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .CLK    (CLK),
        .RESETN (RESETN),
        .hold   (MODE[MODE_STOP_BIT]),
        .clear  (load_time_c),
        .tick_c (tick_c)
    );

    // Out-of-range time fields load as zero.
    function automatic tk_time_t clean_time(input logic [TIME_W-1:0] v);
        tk_time_t t;
        t = tk_time_t'(v);
        if (t.hour > 5'd23) t.hour = '0;
        if (t.min  > 6'd59) t.min  = '0;
        if (t.sec  > 6'd59) t.sec  = '0;
        return t;
    endfunction

    // Date fields are fixed up year first, then month, then day against them.
    function automatic tk_date_t clean_date(input logic [DATE_W-1:0] v);
        tk_date_t   d;
        logic [4:0] dmax;
        d = tk_date_t'(v);
        if (d.year > 7'd99) d.year = 7'd99;
        if ((d.month == 4'd0) || (d.month > 4'd12)) d.month = 4'd1;
        dmax = month_len(d.month, d.year);
        if (d.day == 5'd0)     d.day = 5'd1;
        else if (d.day > dmax) d.day = dmax;
        return d;
    endfunction

    assign ld_t = clean_time(SET_BUS.SET_TIME);
    assign ld_d = clean_date(SET_BUS.SET_DATE);
    assign ld_a = clean_time(SET_BUS.SET_ALARM);

    // One-second advance of the full time/date cascade.
    always_comb begin
        nxt_t = cur_t;
        nxt_d = cur_d;
        if (cur_t.sec != 6'd59) begin
            nxt_t.sec = cur_t.sec + 6'd1;
        end else begin
            nxt_t.sec = '0;
            if (cur_t.min != 6'd59) begin
                nxt_t.min = cur_t.min + 6'd1;
            end else begin
                nxt_t.min = '0;
                if (cur_t.hour != 5'd23) begin
                    nxt_t.hour = cur_t.hour + 5'd1;
                end else begin
                    nxt_t.hour = '0;
                    if (cur_d.day < month_len(cur_d.month, cur_d.year)) begin
                        nxt_d.day = cur_d.day + 5'd1;
                    end else begin
                        nxt_d.day = 5'd1;
                        if (cur_d.month != 4'd12) begin
                            nxt_d.month = cur_d.month + 4'd1;
                        end else begin
                            nxt_d.month = 4'd1;
                            nxt_d.year  = (cur_d.year >= 7'd99) ? 7'd0
                                                                : cur_d.year + 7'd1;
                        end
                    end
                end
            end
        end
    end

    // Acknowledge FSM: one load per request, one-cycle ack, wait for release.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            setting_ok <= 1'b0;
        end else begin
            setting_ok <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_c) begin
                        state      <= ST_ACK;
                        setting_ok <= 1'b1;
                    end
                end
                ST_ACK:  state <= ST_WAIT;
                ST_WAIT: if (!req_c) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Time, date and alarm registers: loads win over the tick.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cur_t   <= '0;
            cur_d   <= tk_date_t'(RESET_DATE);
            alarm_t <= '0;
        end else begin
            if (load_time_c) begin
                cur_t <= ld_t;
                cur_d <= ld_d;
            end
            if (load_alarm_c) begin
                alarm_t <= ld_a;
            end
            if (tick_take_c) begin
                cur_t <= nxt_t;
                cur_d <= nxt_d;
            end
        end
    end

    // Second pulse and alarm hold-off counted in ticks.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sec_tick  <= 1'b0;
            alarm_hit <= 1'b0;
            alarm_rem <= '0;
        end else begin
            sec_tick <= tick_take_c;
            if (!ALARM_ENABLE) begin
                alarm_hit <= 1'b0;
                alarm_rem <= '0;
            end else if (tick_take_c) begin
                if (nxt_t == alarm_t) begin
                    alarm_hit <= 1'b1;
                    alarm_rem <= REM_W'(ALARM_SEC);
                end else if (alarm_hit) begin
                    if (alarm_rem <= REM_W'(1)) begin
                        alarm_hit <= 1'b0;
                        alarm_rem <= '0;
                    end else begin
                        alarm_rem <= alarm_rem - REM_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed checks of loading, cascade, clamping, freeze,
// alarm and reset behaviour with a fast prescaler.
module tb_time_keeper;
    import time_keeper_pkg::*;

    localparam int unsigned HZ = 4;
`ifdef TIME_KEEPER_LEAP_EN
    localparam logic LEAP = 1'b1;
`else
    localparam logic LEAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [5:0]  MODE;
    logic        ALARM_ENABLE;
    logic [16:0] CUR_TIME;
    logic [15:0] CUR_DATE;
    logic [16:0] CUR_ALARM;
    logic        SEC_TICK;
    logic        ALARM_HIT;

    int n_cmp = 0;
    int n_mis = 0;
    int ticks;

    time_keeper_if bus();

    time_keeper #(
        .CLK_HZ    (HZ),
        .ALARM_SEC (30)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .MODE         (MODE),
        .ALARM_ENABLE (ALARM_ENABLE),
        .SET_BUS      (bus),
        .CUR_TIME     (CUR_TIME),
        .CUR_DATE     (CUR_DATE),
        .CUR_ALARM    (CUR_ALARM),
        .SEC_TICK     (SEC_TICK),
        .ALARM_HIT    (ALARM_HIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [15:0] ymd(input int y, input int m, input int d);
        return {7'(y), 4'(m), 5'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Raise the requests, wait for the load edge, check the ack, release.
    task automatic load(input logic set, input logic aset, input logic [16:0] t,
                        input logic [15:0] d, input logic [16:0] a);
        bus.SETTING       = set;
        bus.ALARM_SETTING = aset;
        bus.SET_TIME      = t;
        bus.SET_DATE      = d;
        bus.SET_ALARM     = a;
        cyc(1);
        check("ack", 32'(SETTING_OK_w()), 32'd1);
        bus.SETTING       = 1'b0;
        bus.ALARM_SETTING = 1'b0;
    endtask

    function automatic logic SETTING_OK_w();
        return bus.SETTING_OK;
    endfunction

    initial begin
        RESETN            = 1'b0;
        MODE              = '0;
        ALARM_ENABLE      = 1'b0;
        bus.SETTING       = 1'b0;
        bus.ALARM_SETTING = 1'b0;
        bus.SET_TIME      = '0;
        bus.SET_DATE      = '0;
        bus.SET_ALARM     = '0;
        cyc(2);
        check("rst_time",  32'(CUR_TIME),  32'h0);
        check("rst_date",  32'(CUR_DATE),  32'h0021);
        check("rst_alarm", 32'(CUR_ALARM), 32'h0);
        check("rst_ok",    32'(bus.SETTING_OK), 32'h0);
        check("rst_tick",  32'(SEC_TICK),  32'h0);
        check("rst_hit",   32'(ALARM_HIT), 32'h0);
        RESETN = 1'b1;

        // Three seconds of free counting.
        ticks = 0;
        for (int i = 0; i < 3 * int'(HZ); i++) begin
            cyc(1);
            if (SEC_TICK) ticks++;
        end
        check("run3_time",  32'(CUR_TIME), 32'(hms(0, 0, 3)));
        check("run3_ticks", 32'(ticks), 32'd3);

        // Full rollover at end of century.
        load(1'b1, 1'b0, hms(23, 59, 59), ymd(99, 12, 31), '0);
        check("roll_ld_time", 32'(CUR_TIME), 32'(hms(23, 59, 59)));
        check("roll_ld_date", 32'(CUR_DATE), 32'(ymd(99, 12, 31)));
        cyc(1);
        check("roll_ok_drop", 32'(bus.SETTING_OK), 32'h0);
        cyc(HZ - 2);
        check("roll_pre_time", 32'(CUR_TIME), 32'(hms(23, 59, 59)));
        check("roll_pre_tick", 32'(SEC_TICK), 32'h0);
        cyc(1);
        check("roll_time", 32'(CUR_TIME), 32'(hms(0, 0, 0)));
        check("roll_date", 32'(CUR_DATE), 32'h0021);
        check("roll_tick", 32'(SEC_TICK), 32'h1);

        // February end, with and without leap years.
        load(1'b1, 1'b0, hms(23, 59, 59), ymd(4, 2, 28), '0);
        cyc(HZ);
        check("feb28_next", 32'(CUR_DATE), LEAP ? 32'(ymd(4, 2, 29)) : 32'(ymd(4, 3, 1)));
        load(1'b1, 1'b0, hms(23, 59, 59), ymd(4, 2, 29), '0);
        check("feb29_load", 32'(CUR_DATE), LEAP ? 32'(ymd(4, 2, 29)) : 32'(ymd(4, 2, 28)));
        cyc(HZ);
        check("feb_end_next", 32'(CUR_DATE), 32'(ymd(4, 3, 1)));

        // Load sanitising.
        load(1'b1, 1'b0, hms(1, 0, 0), ymd(1, 2, 31), '0);
        check("clamp_feb", 32'(CUR_DATE), 32'(ymd(1, 2, 28)));
        cyc(2);
        load(1'b1, 1'b0, hms(1, 0, 0), ymd(5, 13, 10), '0);
        check("clamp_mon13", 32'(CUR_DATE), 32'(ymd(5, 1, 10)));
        cyc(2);
        load(1'b1, 1'b0, hms(1, 0, 0), ymd(7, 4, 31), '0);
        check("clamp_apr", 32'(CUR_DATE), 32'(ymd(7, 4, 30)));
        cyc(2);
        load(1'b1, 1'b0, hms(24, 60, 30), ymd(120, 6, 0), '0);
        check("clamp_time", 32'(CUR_TIME), 32'(hms(0, 0, 30)));
        check("clamp_ydate", 32'(CUR_DATE), 32'(ymd(99, 6, 1)));
        cyc(2);

        // Freeze counting.
        load(1'b1, 1'b0, hms(12, 34, 56), ymd(10, 5, 5), '0);
        MODE = 6'b000001;
        ticks = 0;
        for (int i = 0; i < 2 * int'(HZ); i++) begin
            cyc(1);
            if (SEC_TICK) ticks++;
        end
        check("frz_ticks", 32'(ticks), 32'd0);
        check("frz_time",  32'(CUR_TIME), 32'(hms(12, 34, 56)));
        MODE = '0;
        cyc(HZ - 1);
        check("frz_pre", 32'(CUR_TIME), 32'(hms(12, 34, 56)));
        cyc(1);
        check("frz_resume", 32'(CUR_TIME), 32'(hms(12, 34, 57)));

        // Alarm trigger and 30-tick hold.
        ALARM_ENABLE = 1'b1;
        load(1'b1, 1'b1, hms(0, 0, 0), ymd(0, 1, 1), hms(0, 0, 5));
        check("al_stored", 32'(CUR_ALARM), 32'(hms(0, 0, 5)));
        cyc(1);
        check("al_one_ack", 32'(bus.SETTING_OK), 32'h0);
        cyc(5 * HZ - 2);
        check("al_pre_time", 32'(CUR_TIME), 32'(hms(0, 0, 4)));
        check("al_pre_hit",  32'(ALARM_HIT), 32'h0);
        cyc(1);
        check("al_time",  32'(CUR_TIME), 32'(hms(0, 0, 5)));
        check("al_hit",   32'(ALARM_HIT), 32'h1);
        check("al_tick",  32'(SEC_TICK), 32'h1);
        cyc(29 * HZ);
        check("al_hold_time", 32'(CUR_TIME), 32'(hms(0, 0, 34)));
        check("al_hold_hit",  32'(ALARM_HIT), 32'h1);
        cyc(HZ);
        check("al_end_hit", 32'(ALARM_HIT), 32'h0);

        // Enable drop clears the alarm on the next edge.
        load(1'b1, 1'b0, hms(0, 0, 4), ymd(0, 1, 1), '0);
        cyc(HZ);
        check("al2_hit", 32'(ALARM_HIT), 32'h1);
        ALARM_ENABLE = 1'b0;
        cyc(1);
        check("al2_clear", 32'(ALARM_HIT), 32'h0);
        cyc(2);

        // No reload in WAIT; reset mid-handshake restarts it.
        bus.SETTING  = 1'b1;
        bus.SET_TIME = hms(1, 2, 3);
        bus.SET_DATE = ymd(2, 3, 4);
        cyc(1);
        check("mh_ok", 32'(bus.SETTING_OK), 32'h1);
        bus.SET_TIME = hms(4, 5, 6);
        cyc(2);
        check("mh_wait_time", 32'(CUR_TIME), 32'(hms(1, 2, 3)));
        check("mh_wait_ok",   32'(bus.SETTING_OK), 32'h0);
        RESETN = 1'b0;
        #1;
        check("mh_rst_time", 32'(CUR_TIME), 32'h0);
        check("mh_rst_date", 32'(CUR_DATE), 32'h0021);
        cyc(1);
        RESETN = 1'b1;
        cyc(1);
        check("mh_re_ok",   32'(bus.SETTING_OK), 32'h1);
        check("mh_re_time", 32'(CUR_TIME), 32'(hms(4, 5, 6)));
        bus.SETTING = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
